character_fsm: RTL

CHARACTER_FSM -- requirements
Module: character_fsm

---
 rtl/character_pkg.sv | 32 +++
 rtl/frame_tick_gen.sv | 31 +++
 rtl/character_fsm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/character_pkg.sv
// -----------------------------------------------------------------------------
// character_pkg
// Shared definitions for one fighting-game character: the state encoding seen
// by the renderer and collision logic, the default attack/stun phase lengths
// (in frame ticks), and the default horizontal play-field bounds.
// No ports (package).
// -----------------------------------------------------------------------------
package character_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_WINDUP  = 3'd2,
    ST_STRIKE  = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DEFEND  = 3'd5,
    ST_STUN    = 3'd6
  } char_state_t;

  // Default phase lengths in frame ticks (legal range 1..15).
  localparam logic [3:0] WINDUP_TICKS  = 4'd4;
  localparam logic [3:0] ACTIVE_TICKS  = 4'd3;
  localparam logic [3:0] RECOVER_TICKS = 4'd6;
  localparam logic [3:0] STUN_TICKS    = 4'd10;

  // Default play-field bounds and motion.
  localparam logic [9:0] X_MIN_DEF   = 10'd0;
  localparam logic [9:0] X_MAX_DEF   = 10'd575;
  localparam logic [9:0] X_START_DEF = 10'd160;
  localparam logic [9:0] STEP_DEF    = 10'd2;

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Turns a frame-rate level (e.g. VGA vsync) into a single-clock pulse on its
// rising edge. The pulse is combinational from the input so an already
// one-cycle tick passes through with no added latency.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_vsync  frame level / pulse input
//   o_tick   one-clock pulse per rising edge of i_vsync
// -----------------------------------------------------------------------------
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
    end
  end

  assign o_tick = i_vsync & ~r_vsync_d;

endmodule

// File: rtl/character_fsm.sv
// -----------------------------------------------------------------------------
// character_fsm
// Per-character controller: walking with clamped position, a three-phase
// attack (windup / strike / recover), blocking, and hit stun. Everything
// except hit capture advances only on frame ticks.
// Ports:
//   Clk            system clock
//   Reset_n        synchronous active-low reset
//   frame_tick     one-clock pulse per video frame
//   move_l/move_r  walk keys (levels)
//   attack         attack key (level, edge-qualified per tick)
//   defense        block key (level)
//   hit            one-clock pulse from collision logic
//   pos_x          horizontal position
//   facing         1 = right, 0 = left
//   state          char_state_t encoding
//   hitbox_active  high in STRIKE
//   blocking       high in DEFEND
//   block_evt      one-clock pulse when a hit is absorbed while blocking
//   anim_idx       ticks spent in the current state (wraps, cleared on change)
// -----------------------------------------------------------------------------
module character_fsm
  import character_pkg::*;
#(
  parameter logic [9:0] X_START   = X_START_DEF,
  parameter logic [9:0] X_MIN     = X_MIN_DEF,
  parameter logic [9:0] X_MAX     = X_MAX_DEF,
  parameter logic [9:0] STEP      = STEP_DEF,
  parameter logic [3:0] WINDUP    = WINDUP_TICKS,
  parameter logic [3:0] ACTIVE    = ACTIVE_TICKS,
  parameter logic [3:0] RECOVER   = RECOVER_TICKS,
  parameter logic [3:0] STUN      = STUN_TICKS,
  parameter logic       FACE_INIT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       move_l,
  input  logic       move_r,
  input  logic       attack,
  input  logic       defense,
  input  logic       hit,
  output logic [9:0] pos_x,
  output logic       facing,
  output logic [2:0] state,
  output logic       hitbox_active,
  output logic       blocking,
  output logic       block_evt,
  output logic [3:0] anim_idx
);

  // Saturating moves done in 11 bits so neither direction can wrap.
  function automatic logic [9:0] sat_left(input logic [9:0] pos,
                                          input logic [9:0] step,
                                          input logic [9:0] lo);
    logic [10:0] floor_v;
    floor_v = {1'b0, lo} + {1'b0, step};
    if ({1'b0, pos} >= floor_v) return pos - step;
    return lo;
  endfunction

  function automatic logic [9:0] sat_right(input logic [9:0] pos,
                                           input logic [9:0] step,
                                           input logic [9:0] hi);
    logic [10:0] sum_v;
    sum_v = {1'b0, pos} + {1'b0, step};
    if (sum_v > {1'b0, hi}) return hi;
    return sum_v[9:0];
  endfunction

  char_state_t r_state;
  logic [9:0]  r_pos;
  logic        r_facing;
  logic [3:0]  r_timer;
  logic [3:0]  r_anim;
  logic        r_hit_pend;
  logic        r_attack_prev;
  logic        r_block_evt;

  logic w_tick;
  logic w_hit_now;
  logic w_attack_go;

  frame_tick_gen u_tick (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_vsync (frame_tick),
    .o_tick  (w_tick)
  );

  // A hit arriving on the tick itself counts together with any pending one.
  assign w_hit_now   = r_hit_pend | hit;
  assign w_attack_go = attack & ~r_attack_prev;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state       <= ST_IDLE;
      r_pos         <= X_START;
      r_facing      <= FACE_INIT;
      r_timer       <= '0;
      r_anim        <= '0;
      r_hit_pend    <= 1'b0;
      r_attack_prev <= 1'b1;   // a key held through reset is not an attack
      r_block_evt   <= 1'b0;
    end else begin
      r_block_evt <= 1'b0;
      if (!w_tick) begin
        r_hit_pend <= r_hit_pend | hit;
      end else begin
        r_hit_pend    <= 1'b0;
        r_attack_prev <= attack;
        // Default: stay and count; every state change below clears it.
        r_anim        <= r_anim + 4'd1;
        case (r_state)
          ST_IDLE, ST_WALK: begin
            if (w_hit_now) begin
              r_state <= ST_STUN;
              r_timer <= STUN;
              r_anim  <= '0;
            end else if (w_attack_go) begin
              r_state <= ST_WINDUP;
              r_timer <= WINDUP;
              r_anim  <= '0;
            end else if (defense) begin
              r_state <= ST_DEFEND;
              r_timer <= '0;
              r_anim  <= '0;
            end else if (move_l ^ move_r) begin
              r_state  <= ST_WALK;
              r_facing <= move_r;
              r_pos    <= move_r ? sat_right(r_pos, STEP, X_MAX)
                                 : sat_left(r_pos, STEP, X_MIN);
              if (r_state != ST_WALK) r_anim <= '0;
            end else begin
              r_state <= ST_IDLE;
              if (r_state != ST_IDLE) r_anim <= '0;
            end
          end
          ST_WINDUP, ST_STRIKE, ST_RECOVER: begin
            if (w_hit_now) begin
              r_state <= ST_STUN;
              r_timer <= STUN;
              r_anim  <= '0;
            end else if (r_timer == 4'd1) begin
              r_anim <= '0;
              if (r_state == ST_WINDUP) begin
                r_state <= ST_STRIKE;
                r_timer <= ACTIVE;
              end else if (r_state == ST_STRIKE) begin
                r_state <= ST_RECOVER;
                r_timer <= RECOVER;
              end else begin
                r_state <= ST_IDLE;
                r_timer <= '0;
              end
            end else begin
              r_timer <= r_timer - 4'd1;
            end
          end
          ST_DEFEND: begin
            // An incoming hit is absorbed and takes precedence over release.
            if (w_hit_now) begin
              r_block_evt <= 1'b1;
            end else if (!defense) begin
              r_state <= ST_IDLE;
              r_anim  <= '0;
            end
          end
          ST_STUN: begin
            if (w_hit_now) begin
              r_timer <= STUN;
            end else if (r_timer == 4'd1) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_anim  <= '0;
            end else begin
              r_timer <= r_timer - 4'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_anim  <= '0;
          end
        endcase
      end
    end
  end

  assign pos_x         = r_pos;
  assign facing        = r_facing;
  assign state         = r_state;
  assign hitbox_active = (r_state == ST_STRIKE);
  assign blocking      = (r_state == ST_DEFEND);
  assign block_evt     = r_block_evt;
  assign anim_idx      = r_anim;

endmodule
